// File: rtl/max7219_pkg.sv
// Shared constants, FSM encoding and the Code-B segment table for the MAX7219 responder.
package max7219_pkg;

  localparam int unsigned FRAME_BITS = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Register-file reset values; the chip powers up in shutdown.
  localparam logic [7:0] RST_DIGIT      = 8'h00;
  localparam logic [7:0] RST_DECODE     = 8'h00;
  localparam logic [3:0] RST_INTENSITY  = 4'h0;
  localparam logic [2:0] RST_SCANLIM    = 3'd0;
  localparam logic       RST_SHUTDOWN_N = 1'b0;
  localparam logic       RST_TEST       = 1'b0;

  // Synchroniser reset values; CS idles high so a low CS at reset release reads as a fall.
  localparam logic RST_SYNC_CS  = 1'b1;
  localparam logic RST_SYNC_CLK = 1'b0;
  localparam logic RST_SYNC_DIN = 1'b0;

  // Code-B decode: bit 7 = DP, bits 6..0 = segments A..G. 0xA..0xF = '-', E, H, L, P, blank.
  function automatic logic [7:0] codeb_seg(input logic [7:0] d);
    logic [6:0] seg;
    case (d[3:0])
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h01;
      4'hB:    seg = 7'h4F;
      4'hC:    seg = 7'h37;
      4'hD:    seg = 7'h0E;
      4'hE:    seg = 7'h67;
      default: seg = 7'h00;
    endcase
    return {d[7], seg};
  endfunction

endpackage

// File: rtl/max7219_rx_frontend.sv
// Serial front end: synchronises CS/CLK/Din, detects edges, counts bits and shifts data/Dout.
module max7219_rx_frontend
  import max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  CS,
  input  logic                  CLK,
  input  logic                  Din,
  input  logic                  clr_i,
  input  logic                  shift_en_i,
  output logic                  cs_fall_o,
  output logic                  cs_rise_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [FRAME_BITS-1:0] shift_o,
  output logic                  dout_o
);

  logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, din_sync_q;
  logic                   cs_prev_q, clk_prev_q;
  logic                   cs_s, clk_s, din_s, clk_rise, clk_fall;
  logic [CNT_W-1:0]       count_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic                   dout_q;

  // Synchroniser chains plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cs_sync_q  <= {SYNC_STAGES{RST_SYNC_CS}};
      clk_sync_q <= {SYNC_STAGES{RST_SYNC_CLK}};
      din_sync_q <= {SYNC_STAGES{RST_SYNC_DIN}};
      cs_prev_q  <= RST_SYNC_CS;
      clk_prev_q <= RST_SYNC_CLK;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], CLK};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], Din};
      cs_prev_q  <= cs_s;
      clk_prev_q <= clk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_fall_o = cs_prev_q & ~cs_s;
  assign cs_rise_o = ~cs_prev_q & cs_s;
  assign clk_rise  = ~clk_prev_q & clk_s;
  assign clk_fall  = clk_prev_q & ~clk_s;

  // Bit counter, shift register and daisy-chain output; a CLK rise coinciding with CS rise is dropped.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      if (clr_i) begin
        count_q <= '0;
      end else if (shift_en_i && clk_rise && !cs_rise_o) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], din_s};
        if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
      end
      if (shift_en_i && clk_fall) dout_q <= shift_q[FRAME_BITS-1];
    end
  end

  assign count_o = count_q;
  assign shift_o = shift_q;
  assign dout_o  = dout_q;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 serial responder: frame FSM, register file and registered 8x8 display image.
// Optional Code-B digit decoding is enabled by defining MAX7219_RX_CODEB_EN.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        CLK,
  input  logic        Din,
  output logic        Dout,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        disp_test,
  output logic [63:0] matrix
);

  state_e                state_q, state_d;
  logic                  cs_fall, cs_rise, clr, shift_en, latch_ok, latch_err;
  logic [CNT_W-1:0]      count;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            f_addr;
  logic [7:0]            f_data;
  logic [2:0]            row_idx;
  logic                  is_digit;

  logic [7:0]  digit_q [8];
  logic [7:0]  decode_q;
  logic [3:0]  intensity_q, frame_addr_q;
  logic [7:0]  frame_data_q;
  logic [2:0]  scan_limit_q;
  logic        shutdown_n_q, disp_test_q, frame_valid_q, frame_err_q;
  logic [63:0] matrix_q, image_d;

  max7219_rx_frontend #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_frontend (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .CS        (CS),
    .CLK       (CLK),
    .Din       (Din),
    .clr_i     (clr),
    .shift_en_i(shift_en),
    .cs_fall_o (cs_fall),
    .cs_rise_o (cs_rise),
    .count_o   (count),
    .shift_o   (shift),
    .dout_o    (Dout)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: LATCH lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counter clear on frame start, shifting enable and latch decision.
  always_comb begin
    clr       = (state_q == IDLE) && cs_fall;
    shift_en  = (state_q == SHIFT);
    latch_ok  = (state_q == LATCH) && (32'(count) >= FRAME_BITS);
    latch_err = (state_q == LATCH) && (32'(count) < FRAME_BITS);
  end

  // Upper nibble of the frame is don't-care on the wire.
  assign f_addr   = shift[11:8];
  assign f_data   = shift[7:0];
  assign is_digit = (f_addr >= ADDR_DIGIT0) && (f_addr <= ADDR_DIGIT7);
  assign row_idx  = 3'(f_addr - ADDR_DIGIT0);

  logic unused_shift_hi;
  assign unused_shift_hi = ^shift[15:12];

  // Register file and frame pulses, written when a complete frame is latched.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) digit_q[k] <= RST_DIGIT;
      decode_q      <= RST_DECODE;
      intensity_q   <= RST_INTENSITY;
      scan_limit_q  <= RST_SCANLIM;
      shutdown_n_q  <= RST_SHUTDOWN_N;
      disp_test_q   <= RST_TEST;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= latch_ok;
      frame_err_q   <= latch_err;
      if (latch_ok) begin
        frame_addr_q <= f_addr;
        frame_data_q <= f_data;
        case (f_addr)
          ADDR_DECODE:    decode_q     <= f_data;
          ADDR_INTENSITY: intensity_q  <= f_data[3:0];
          ADDR_SCANLIM:   scan_limit_q <= f_data[2:0];
          ADDR_SHUTDOWN:  shutdown_n_q <= f_data[0];
          ADDR_TEST:      disp_test_q  <= f_data[0];
          default:        if (is_digit) digit_q[row_idx] <= f_data;
        endcase
      end
    end
  end

  // Display image: test overrides shutdown, which overrides the scan-limited digit rows.
  always_comb begin
    image_d = '0;
    if (disp_test_q) begin
      image_d = '1;
    end else if (shutdown_n_q) begin
      for (int k = 0; k < 8; k++) begin
        if (3'(k) <= scan_limit_q) begin
`ifdef MAX7219_RX_CODEB_EN
          image_d[8*k +: 8] = decode_q[k] ? codeb_seg(digit_q[k]) : digit_q[k];
`else
          image_d[8*k +: 8] = digit_q[k];
`endif
        end
      end
    end
  end

`ifndef MAX7219_RX_CODEB_EN
  logic unused_decode;
  assign unused_decode = ^decode_q;
`endif

  // Registered image, one cycle behind the register file.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) matrix_q <= '0;
    else     matrix_q <= image_d;
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;
  assign intensity   = intensity_q;
  assign scan_limit  = scan_limit_q;
  assign shutdown_n  = shutdown_n_q;
  assign disp_test   = disp_test_q;
  assign matrix      = matrix_q;

endmodule
